// File: rtl/id_stage_v2_if.sv
// Fetch/decode/execute-facing signal bundle of the decode stage.
// The stage connects through the slave modport; the driving side uses master.
interface id_stage_v2_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned PC_W   = 32
);
    localparam int unsigned RA = $clog2(NREGS);

    logic              instr_valid;
    logic [WIDTH-1:0]  instruction;
    logic [2:0]        ccr;
    logic              interrupt;
    logic              ex_mem_read;
    logic [RA-1:0]     ex_rd_in;
    logic              wb_we;
    logic [RA-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              stall;
    logic              fetch_pc_enable;
    logic [1:0]        pc_sel;
    logic [PC_W-1:0]   pc_jmp;

    logic              ex_valid;
    logic [4:0]        ex_opcode;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;
    logic [DATA_W-1:0] ex_imm;
    logic [RA-1:0]     ex_rd;
    logic              ex_reg_wr;
    logic              ex_mem_rd;
    logic              ex_mem_wr;
    logic              ex_stack;
    logic [1:0]        ex_int_push;

    modport master (
        output instr_valid, instruction, ccr, interrupt, ex_mem_read, ex_rd_in,
               wb_we, wb_addr, wb_data,
        input  stall, fetch_pc_enable, pc_sel, pc_jmp,
               ex_valid, ex_opcode, ex_op1, ex_op2, ex_imm, ex_rd,
               ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_stack, ex_int_push
    );

    modport slave (
        input  instr_valid, instruction, ccr, interrupt, ex_mem_read, ex_rd_in,
               wb_we, wb_addr, wb_data,
        output stall, fetch_pc_enable, pc_sel, pc_jmp,
               ex_valid, ex_opcode, ex_op1, ex_op2, ex_imm, ex_rd,
               ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_stack, ex_int_push
    );
endinterface

// File: rtl/id_stage_v2.sv
// Decode stage: register file, registered ID/EX latch, jump resolution in ID,
// load-use stall, two-word LDM assembly and interrupt entry sequencing.
module id_stage_v2 #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned PC_W   = 32
) (
    input logic          clk,
    input logic          rst,
    id_stage_v2_if.slave bus
);
    localparam int unsigned RA = $clog2(NREGS);

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LDM  = 5'b01000;
    localparam logic [4:0] OP_LDD  = 5'b01001;
    localparam logic [4:0] OP_STD  = 5'b01010;
    localparam logic [4:0] OP_PUSH = 5'b01100;
    localparam logic [4:0] OP_POP  = 5'b01101;

    typedef enum logic [2:0] {
        S_DEC     = 3'd0,
        S_IMM     = 3'd1,
        S_INT_PC  = 3'd2,
        S_INT_CCR = 3'd3,
        S_INT_VEC = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              kill_q, kill_d;
    logic              int_pend_q, int_pend_d;
    logic [RA-1:0]     ldm_rd_q, ldm_rd_d;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic              ex_valid_q, ex_valid_d;
    logic [4:0]        ex_opcode_q, ex_opcode_d;
    logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
    logic [DATA_W-1:0] ex_op2_q, ex_op2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [RA-1:0]     ex_rd_q, ex_rd_d;
    logic              ex_reg_wr_q, ex_reg_wr_d;
    logic              ex_mem_rd_q, ex_mem_rd_d;
    logic              ex_mem_wr_q, ex_mem_wr_d;
    logic              ex_stack_q, ex_stack_d;
    logic [1:0]        ex_int_push_q, ex_int_push_d;

    logic              stall_c, fetch_pc_enable_c;
    logic [1:0]        pc_sel_c;

    // Instruction fields
    logic [4:0]    op;
    logic [RA-1:0] rs, rd;
    assign op = bus.instruction[WIDTH-1 -: 5];
    assign rs = bus.instruction[WIDTH-6 -: RA];
    assign rd = bus.instruction[WIDTH-6-RA -: RA];

    logic unused_instr_c;
    assign unused_instr_c = ^bus.instruction;

    logic is_alu, is_ldm, is_ldd, is_std, is_push, is_pop, is_jmp, is_op_c;
    assign is_alu  = (op[4:2] == 3'b001);
    assign is_jmp  = (op[4:2] == 3'b110);
    assign is_ldm  = (op == OP_LDM);
    assign is_ldd  = (op == OP_LDD);
    assign is_std  = (op == OP_STD);
    assign is_push = (op == OP_PUSH);
    assign is_pop  = (op == OP_POP);
    assign is_op_c = is_alu | is_ldm | is_ldd | is_std | is_push | is_pop | is_jmp;

    // Register reads with write-through bypass from writeback
    logic [DATA_W-1:0] op1_c, op2_c;
    assign op1_c = (bus.wb_we && (bus.wb_addr == rs)) ? bus.wb_data : regs_q[rs];
    assign op2_c = (bus.wb_we && (bus.wb_addr == rd)) ? bus.wb_data : regs_q[rd];

    // A word is live only in DEC, when present, and when not squashed by a prior jump
    logic live_c, hazard_c, cond_c, taken_c;
    assign live_c   = (state_q == S_DEC) && bus.instr_valid && !kill_q;
    assign hazard_c = live_c && is_op_c && bus.ex_mem_read &&
                      ((bus.ex_rd_in == rs) || (bus.ex_rd_in == rd));

    always_comb begin
        cond_c = 1'b1;
        case (op[1:0])
            2'b00:   cond_c = bus.ccr[0];
            2'b01:   cond_c = bus.ccr[1];
            2'b10:   cond_c = bus.ccr[2];
            default: cond_c = 1'b1;
        endcase
    end

    assign taken_c = live_c && is_jmp && cond_c && !hazard_c;

    // Next-state, ID/EX latch contents and fetch controls
    always_comb begin
        state_d           = state_q;
        kill_d            = kill_q;
        int_pend_d        = int_pend_q | bus.interrupt;
        ldm_rd_d          = ldm_rd_q;
        stall_c           = 1'b0;
        fetch_pc_enable_c = 1'b1;
        pc_sel_c          = 2'd0;
        ex_valid_d        = 1'b0;
        ex_opcode_d       = OP_NOP;
        ex_op1_d          = '0;
        ex_op2_d          = '0;
        ex_imm_d          = '0;
        ex_rd_d           = '0;
        ex_reg_wr_d       = 1'b0;
        ex_mem_rd_d       = 1'b0;
        ex_mem_wr_d       = 1'b0;
        ex_stack_d        = 1'b0;
        ex_int_push_d     = 2'b00;

        case (state_q)
            S_DEC: begin
                if (!bus.instr_valid) begin
                    if (int_pend_q) state_d = S_INT_PC;
                end else if (kill_q) begin
                    kill_d = 1'b0;
                    if (int_pend_q) state_d = S_INT_PC;
                end else if (hazard_c) begin
                    stall_c           = 1'b1;
                    fetch_pc_enable_c = 1'b0;
                end else if (taken_c) begin
                    pc_sel_c = 2'd1;
                    kill_d   = 1'b1;
                end else if (is_ldm) begin
                    // LDM owns the next word, so a pending interrupt waits for it
                    state_d  = S_IMM;
                    ldm_rd_d = rd;
                end else begin
                    if (!is_jmp) begin
                        ex_valid_d  = 1'b1;
                        ex_opcode_d = is_op_c ? op : OP_NOP;
                        ex_op1_d    = op1_c;
                        ex_op2_d    = op2_c;
                        ex_rd_d     = rd;
                        ex_reg_wr_d = is_alu | is_ldd | is_pop;
                        ex_mem_rd_d = is_ldd | is_pop;
                        ex_mem_wr_d = is_std | is_push;
                        ex_stack_d  = is_push | is_pop;
                    end
                    if (int_pend_q) state_d = S_INT_PC;
                end
            end
            S_IMM: begin
                stall_c           = 1'b1;
                fetch_pc_enable_c = 1'b0;
                if (bus.instr_valid) begin
                    fetch_pc_enable_c = 1'b1;
                    ex_valid_d        = 1'b1;
                    ex_opcode_d       = OP_LDM;
                    ex_imm_d          = DATA_W'(bus.instruction);
                    ex_rd_d           = ldm_rd_q;
                    ex_reg_wr_d       = 1'b1;
                    state_d           = S_DEC;
                end
            end
            S_INT_PC, S_INT_CCR: begin
                stall_c           = 1'b1;
                fetch_pc_enable_c = 1'b0;
                ex_valid_d        = 1'b1;
                ex_stack_d        = 1'b1;
                ex_mem_wr_d       = 1'b1;
                ex_int_push_d     = (state_q == S_INT_PC) ? 2'b01 : 2'b10;
                state_d           = (state_q == S_INT_PC) ? S_INT_CCR : S_INT_VEC;
            end
            S_INT_VEC: begin
                pc_sel_c   = 2'd2;
                int_pend_d = 1'b0;
                state_d    = S_DEC;
            end
            default: state_d = S_DEC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_DEC;
            kill_q        <= 1'b0;
            int_pend_q    <= 1'b0;
            ldm_rd_q      <= '0;
            ex_valid_q    <= 1'b0;
            ex_opcode_q   <= OP_NOP;
            ex_op1_q      <= '0;
            ex_op2_q      <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_reg_wr_q   <= 1'b0;
            ex_mem_rd_q   <= 1'b0;
            ex_mem_wr_q   <= 1'b0;
            ex_stack_q    <= 1'b0;
            ex_int_push_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            kill_q        <= kill_d;
            int_pend_q    <= int_pend_d;
            ldm_rd_q      <= ldm_rd_d;
            ex_valid_q    <= ex_valid_d;
            ex_opcode_q   <= ex_opcode_d;
            ex_op1_q      <= ex_op1_d;
            ex_op2_q      <= ex_op2_d;
            ex_imm_q      <= ex_imm_d;
            ex_rd_q       <= ex_rd_d;
            ex_reg_wr_q   <= ex_reg_wr_d;
            ex_mem_rd_q   <= ex_mem_rd_d;
            ex_mem_wr_q   <= ex_mem_wr_d;
            ex_stack_q    <= ex_stack_d;
            ex_int_push_q <= ex_int_push_d;
        end
    end

    // Register file
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (bus.wb_we) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign bus.stall           = stall_c;
    assign bus.fetch_pc_enable = fetch_pc_enable_c;
    assign bus.pc_sel          = pc_sel_c;
    assign bus.pc_jmp          = taken_c ? PC_W'(op2_c) : '0;

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_opcode   = ex_opcode_q;
    assign bus.ex_op1      = ex_op1_q;
    assign bus.ex_op2      = ex_op2_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_reg_wr   = ex_reg_wr_q;
    assign bus.ex_mem_rd   = ex_mem_rd_q;
    assign bus.ex_mem_wr   = ex_mem_wr_q;
    assign bus.ex_stack    = ex_stack_q;
    assign bus.ex_int_push = ex_int_push_q;
endmodule

// File: tb/tb_id_stage_v2.sv
// Directed bench for id_stage_v2: reset, bypass, load-use, jumps, LDM and interrupts.
module tb_id_stage_v2;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned PC_W   = 32;

    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_SUB = 5'b00101;
    localparam logic [4:0] OP_LDM = 5'b01000;
    localparam logic [4:0] OP_JZ  = 5'b11000;
    localparam logic [4:0] OP_JN  = 5'b11001;
    localparam logic [4:0] OP_JC  = 5'b11010;
    localparam logic [4:0] OP_JMP = 5'b11011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_stage_v2_if #(.WIDTH(WIDTH), .DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W)) bus ();

    id_stage_v2 #(.WIDTH(WIDTH), .DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rd);
        return {op, rs, rd, 5'b00000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        bus.ccr         = 3'b000;
        bus.interrupt   = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rd_in    = '0;
        bus.wb_we       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
    endtask

    task automatic drive(input logic [15:0] w);
        bus.instr_valid = 1'b1;
        bus.instruction = w;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        drive(mk(OP_ADD, 3'd1, 3'd2));
        tick();
        tick();
        idle();
        #1;
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid: got %0h want 0", bus.ex_valid); end
        checks++; if ({bus.ex_opcode, bus.ex_op1, bus.ex_op2, bus.ex_imm, bus.ex_rd} !== '0) begin errors++; $display("FAIL rst_ex_data: got op=%0h op1=%0h op2=%0h imm=%0h rd=%0h want all 0", bus.ex_opcode, bus.ex_op1, bus.ex_op2, bus.ex_imm, bus.ex_rd); end
        checks++; if ({bus.ex_reg_wr, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_stack, bus.ex_int_push} !== 6'b0) begin errors++; $display("FAIL rst_ex_ctrl: got %0h want 0", {bus.ex_reg_wr, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_stack, bus.ex_int_push}); end
        checks++; if ({bus.stall, bus.fetch_pc_enable, bus.pc_sel} !== 4'b0100) begin errors++; $display("FAIL rst_fetch: got stall/pce/sel=%b want 0100", {bus.stall, bus.fetch_pc_enable, bus.pc_sel}); end
        checks++; if (bus.pc_jmp !== 32'h0) begin errors++; $display("FAIL rst_pc_jmp: got %0h want 0", bus.pc_jmp); end
        rst = 1'b1;
    endtask

    task automatic test_bypass();
        bus.wb_we = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 16'h00AB;
        drive(mk(OP_ADD, 3'd3, 3'd1));
        tick();
        checks++; if (bus.ex_op1 !== 16'h00AB) begin errors++; $display("FAIL bypass_op1: got %0h want 00ab", bus.ex_op1); end
        checks++; if ({bus.ex_valid, bus.ex_reg_wr, bus.ex_opcode, bus.ex_rd} !== {1'b1, 1'b1, OP_ADD, 3'd1}) begin errors++; $display("FAIL bypass_ctrl: got v=%0h wr=%0h op=%0h rd=%0h want 1 1 04 1", bus.ex_valid, bus.ex_reg_wr, bus.ex_opcode, bus.ex_rd); end
        bus.wb_we = 1'b0;
        drive(mk(OP_ADD, 3'd1, 3'd3));
        tick();
        checks++; if (bus.ex_op2 !== 16'h00AB) begin errors++; $display("FAIL rf_stored: got %0h want 00ab", bus.ex_op2); end
        idle();
    endtask

    task automatic test_load_use();
        drive(mk(OP_SUB, 3'd1, 3'd2));
        bus.ex_mem_read = 1'b1; bus.ex_rd_in = 3'd2;
        #1;
        checks++; if ({bus.stall, bus.fetch_pc_enable} !== 2'b10) begin errors++; $display("FAIL lu_stall: got stall/pce=%b want 10", {bus.stall, bus.fetch_pc_enable}); end
        tick();
        checks++; if ({bus.ex_valid, bus.ex_reg_wr} !== 2'b00) begin errors++; $display("FAIL lu_bubble: got v/wr=%b want 00", {bus.ex_valid, bus.ex_reg_wr}); end
        bus.ex_mem_read = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %0h want 0", bus.stall); end
        tick();
        checks++; if ({bus.ex_valid, bus.ex_opcode, bus.ex_rd} !== {1'b1, OP_SUB, 3'd2}) begin errors++; $display("FAIL lu_redecode: got v=%0h op=%0h rd=%0h want 1 05 2", bus.ex_valid, bus.ex_opcode, bus.ex_rd); end
        // A NOP never raises the hazard, even with matching register fields
        drive(16'h0000);
        bus.ex_mem_read = 1'b1; bus.ex_rd_in = 3'd0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_nop: got %0h want 0", bus.stall); end
        tick();
        idle();
    endtask

    task automatic test_jump();
        bus.wb_we = 1'b1; bus.wb_addr = 3'd5; bus.wb_data = 16'h0040;
        tick();
        idle();
        bus.ccr = 3'b001;
        drive(mk(OP_JZ, 3'd0, 3'd5));
        #1;
        checks++; if (bus.pc_sel !== 2'd1) begin errors++; $display("FAIL jz_sel: got %0d want 1", bus.pc_sel); end
        checks++; if (bus.pc_jmp !== 32'h00000040) begin errors++; $display("FAIL jz_target: got %0h want 40", bus.pc_jmp); end
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL jz_latch: got %0h want 0", bus.ex_valid); end
        drive(mk(OP_ADD, 3'd1, 3'd1));
        #1;
        checks++; if (bus.pc_sel !== 2'd0) begin errors++; $display("FAIL jz_kill_sel: got %0d want 0", bus.pc_sel); end
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL jz_squash: got %0h want 0", bus.ex_valid); end
        tick();
        checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL jz_after: got %0h want 1", bus.ex_valid); end

        bus.ccr = 3'b000;
        drive(mk(OP_JZ, 3'd0, 3'd5));
        #1;
        checks++; if (bus.pc_sel !== 2'd0) begin errors++; $display("FAIL jz_nt_sel: got %0d want 0", bus.pc_sel); end
        tick();
        drive(mk(OP_ADD, 3'd2, 3'd1));
        tick();
        checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL jz_nt_next: got %0h want 1", bus.ex_valid); end

        // Kill survives an empty fetch slot
        drive(mk(OP_JMP, 3'd0, 3'd5));
        #1;
        checks++; if ({bus.pc_sel, bus.pc_jmp} !== {2'd1, 32'h40}) begin errors++; $display("FAIL jmp_sel: got sel=%0d tgt=%0h want 1 40", bus.pc_sel, bus.pc_jmp); end
        tick();
        bus.instr_valid = 1'b0;
        tick();
        drive(mk(OP_ADD, 3'd1, 3'd1));
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL jmp_kill_hold: got %0h want 0", bus.ex_valid); end

        bus.ccr = 3'b010;
        drive(mk(OP_JN, 3'd0, 3'd5));
        #1;
        checks++; if (bus.pc_sel !== 2'd1) begin errors++; $display("FAIL jn_sel: got %0d want 1", bus.pc_sel); end
        tick();
        drive(16'h0000);
        tick();
        bus.ccr = 3'b011;
        drive(mk(OP_JC, 3'd0, 3'd5));
        #1;
        checks++; if (bus.pc_sel !== 2'd0) begin errors++; $display("FAIL jc_nt_sel: got %0d want 0", bus.pc_sel); end
        tick();

        // Load-use hazard outranks a taken jump
        bus.ccr = 3'b001;
        bus.ex_mem_read = 1'b1; bus.ex_rd_in = 3'd5;
        drive(mk(OP_JZ, 3'd0, 3'd5));
        #1;
        checks++; if ({bus.stall, bus.pc_sel} !== 3'b100) begin errors++; $display("FAIL hz_jmp: got stall/sel=%b want 100", {bus.stall, bus.pc_sel}); end
        tick();
        bus.ex_mem_read = 1'b0;
        #1;
        checks++; if (bus.pc_sel !== 2'd1) begin errors++; $display("FAIL hz_jmp_retry: got %0d want 1", bus.pc_sel); end
        tick();
        drive(16'h0000);
        tick();
        idle();
    endtask

    task automatic test_ldm();
        drive(mk(OP_LDM, 3'd0, 3'd4));
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ldm_first_stall: got %0h want 0", bus.stall); end
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL ldm_bubble: got %0h want 0", bus.ex_valid); end
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if ({bus.stall, bus.fetch_pc_enable} !== 2'b10) begin errors++; $display("FAIL ldm_wait_fetch: got stall/pce=%b want 10", {bus.stall, bus.fetch_pc_enable}); end
            tick();
            checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL ldm_wait_latch: got %0h want 0", bus.ex_valid); end
        end
        drive(16'h1234);
        #1;
        checks++; if (bus.fetch_pc_enable !== 1'b1) begin errors++; $display("FAIL ldm_consume_pce: got %0h want 1", bus.fetch_pc_enable); end
        tick();
        checks++; if ({bus.ex_valid, bus.ex_reg_wr, bus.ex_rd, bus.ex_opcode} !== {1'b1, 1'b1, 3'd4, OP_LDM}) begin errors++; $display("FAIL ldm_ctrl: got v=%0h wr=%0h rd=%0h op=%0h want 1 1 4 08", bus.ex_valid, bus.ex_reg_wr, bus.ex_rd, bus.ex_opcode); end
        checks++; if (bus.ex_imm !== 16'h1234) begin errors++; $display("FAIL ldm_imm: got %0h want 1234", bus.ex_imm); end
        drive(mk(OP_ADD, 3'd1, 3'd1));
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ldm_back_dec: got %0h want 0", bus.stall); end
        tick();
        idle();
    endtask

    task automatic test_interrupt();
        bus.interrupt = 1'b1;
        tick();
        bus.interrupt = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL int_pend_dec: got %0h want 0", bus.stall); end
        tick();
        checks++; if ({bus.stall, bus.fetch_pc_enable} !== 2'b10) begin errors++; $display("FAIL int_pc_fetch: got stall/pce=%b want 10", {bus.stall, bus.fetch_pc_enable}); end
        bus.interrupt = 1'b1;
        tick();
        bus.interrupt = 1'b0;
        checks++; if ({bus.ex_valid, bus.ex_int_push, bus.ex_stack, bus.ex_mem_wr, bus.stall} !== 6'b1_01_111) begin errors++; $display("FAIL int_push_pc: got %b want 101111", {bus.ex_valid, bus.ex_int_push, bus.ex_stack, bus.ex_mem_wr, bus.stall}); end
        tick();
        checks++; if ({bus.ex_valid, bus.ex_int_push, bus.ex_stack, bus.ex_mem_wr} !== 5'b1_10_11) begin errors++; $display("FAIL int_push_ccr: got %b want 11011", {bus.ex_valid, bus.ex_int_push, bus.ex_stack, bus.ex_mem_wr}); end
        checks++; if ({bus.pc_sel, bus.fetch_pc_enable} !== 3'b101) begin errors++; $display("FAIL int_vec: got sel/pce=%b want 101", {bus.pc_sel, bus.fetch_pc_enable}); end
        tick();
        checks++; if ({bus.pc_sel, bus.ex_valid, bus.ex_int_push} !== 5'b0) begin errors++; $display("FAIL int_done: got %b want 00000", {bus.pc_sel, bus.ex_valid, bus.ex_int_push}); end
        // The pulse during entry was absorbed by the pending flag
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.stall, bus.pc_sel} !== 3'b000) begin errors++; $display("FAIL int_second_ignored: got stall/sel=%b want 000", {bus.stall, bus.pc_sel}); end
        end

        drive(mk(OP_LDM, 3'd0, 3'd6));
        tick();
        bus.instr_valid = 1'b0;
        bus.interrupt = 1'b1;
        tick();
        bus.interrupt = 1'b0;
        checks++; if ({bus.stall, bus.pc_sel} !== 3'b100) begin errors++; $display("FAIL int_in_imm: got stall/sel=%b want 100", {bus.stall, bus.pc_sel}); end
        drive(16'h00FF);
        tick();
        bus.instr_valid = 1'b0;
        checks++; if ({bus.ex_valid, bus.ex_rd, bus.ex_imm} !== {1'b1, 3'd6, 16'h00FF}) begin errors++; $display("FAIL int_ldm_first: got v=%0h rd=%0h imm=%0h want 1 6 ff", bus.ex_valid, bus.ex_rd, bus.ex_imm); end
        tick();
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL int_deferred_pc: got %0h want 1", bus.stall); end
        tick();
        checks++; if (bus.ex_int_push !== 2'b01) begin errors++; $display("FAIL int_deferred_push: got %b want 01", bus.ex_int_push); end
        tick();
        checks++; if (bus.pc_sel !== 2'd2) begin errors++; $display("FAIL int_deferred_vec: got %0d want 2", bus.pc_sel); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_int();
        bus.interrupt = 1'b1;
        tick();
        bus.interrupt = 1'b0;
        tick();
        tick();
        checks++; if (bus.ex_int_push !== 2'b01) begin errors++; $display("FAIL rmi_in_ccr: got %b want 01", bus.ex_int_push); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if ({bus.ex_valid, bus.ex_int_push, bus.stall, bus.pc_sel} !== 6'b0) begin errors++; $display("FAIL rmi_reset: got %b want 000000", {bus.ex_valid, bus.ex_int_push, bus.stall, bus.pc_sel}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({bus.stall, bus.pc_sel} !== 3'b000) begin errors++; $display("FAIL rmi_no_vec: got stall/sel=%b want 000", {bus.stall, bus.pc_sel}); end
        end
        drive(mk(OP_ADD, 3'd5, 3'd3));
        tick();
        checks++; if ({bus.ex_valid, bus.ex_op1, bus.ex_op2} !== {1'b1, 16'h0, 16'h0}) begin errors++; $display("FAIL rmi_rf_clear: got v=%0h op1=%0h op2=%0h want 1 0 0", bus.ex_valid, bus.ex_op1, bus.ex_op2); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_load_use();
        test_jump();
        test_ldm();
        test_interrupt();
        test_reset_mid_int();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
